// File: rtl/map_ram_arbiter.sv
// Arbitrated single-port map store shared by NUM_PORTS requesters.
// Optional MAP_RAM_RR_EN: round-robin service among player ports.
module map_ram_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [NUM_PORTS-1:0]        rd_req,
  input  logic [NUM_PORTS-1:0]        wr_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        rd_done,
  output logic [NUM_PORTS-1:0]        wr_done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clear_ptr;
  logic [PW-1:0]       g_port;
  logic                g_wr;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic                g_in_rng;

  logic                a_valid;
  logic [PW-1:0]       a_port;
  logic                a_wr;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MAP_RAM_RR_EN
  logic [PW-1:0]       rr_ptr;
  logic [PW:0]         j;

  // Draw read first, then player writes, then player reads, both rotating from rr_ptr
  always_comb begin
    a_valid = 1'b0;
    a_port  = '0;
    a_wr    = 1'b0;
    j       = '0;
    if (rd_req[0]) begin
      a_valid = 1'b1;
    end else begin
      for (int i = 0; i < NUM_PORTS-1; i++) begin
        j = {1'b0, rr_ptr} + (PW+1)'(i);
        if (j >= (PW+1)'(NUM_PORTS))
          j = j - (PW+1)'(NUM_PORTS-1);
        if (!a_valid && wr_req[j[PW-1:0]]) begin
          a_valid = 1'b1;
          a_port  = j[PW-1:0];
          a_wr    = 1'b1;
        end
      end
      for (int i = 0; i < NUM_PORTS-1; i++) begin
        j = {1'b0, rr_ptr} + (PW+1)'(i);
        if (j >= (PW+1)'(NUM_PORTS))
          j = j - (PW+1)'(NUM_PORTS-1);
        if (!a_valid && rd_req[j[PW-1:0]]) begin
          a_valid = 1'b1;
          a_port  = j[PW-1:0];
        end
      end
    end
  end

  // Rotate past each served player; draw port never moves the pointer
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr <= PW'(1);
    end else if (state == S_IDLE && enable && a_valid && a_port != '0) begin
      if (a_port == PW'(NUM_PORTS-1))
        rr_ptr <= PW'(1);
      else
        rr_ptr <= a_port + PW'(1);
    end
  end
`else
  // Fixed order: draw read, player writes ascending, player reads ascending
  always_comb begin
    a_valid = 1'b0;
    a_port  = '0;
    a_wr    = 1'b0;
    if (rd_req[0]) begin
      a_valid = 1'b1;
    end else begin
      for (int i = 1; i < NUM_PORTS; i++) begin
        if (!a_valid && wr_req[i]) begin
          a_valid = 1'b1;
          a_port  = PW'(i);
          a_wr    = 1'b1;
        end
      end
      for (int i = 1; i < NUM_PORTS; i++) begin
        if (!a_valid && rd_req[i]) begin
          a_valid = 1'b1;
          a_port  = PW'(i);
        end
      end
    end
  end
`endif

  assign g_in_rng = {1'b0, g_addr} < DEPTH_V;

  // Single array write path: clearing sweep or committed player write
  always_comb begin
    mem_we = 1'b0;
    mem_wa = g_addr;
    mem_wd = g_wdata;
    if (resetn) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clear_ptr;
        mem_wd = '0;
      end else if (state == S_ACCESS && g_wr && g_in_rng) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array
  always_ff @(posedge clock) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  // Transaction FSM with registered done pulses, read data and busy
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_CLEAR;
      clear_ptr <= '0;
      rd_done   <= '0;
      wr_done   <= '0;
      rdata     <= '0;
      busy      <= 1'b1;
      g_port    <= '0;
      g_wr      <= 1'b0;
      g_addr    <= '0;
      g_wdata   <= '0;
    end else begin
      rd_done <= '0;
      wr_done <= '0;
      unique case (state)
        S_CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          if (clear_ptr == LAST) begin
            clear_ptr <= '0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_IDLE: begin
          if (enable && a_valid) begin
            state   <= S_ACCESS;
            busy    <= 1'b1;
            g_port  <= a_port;
            g_wr    <= a_wr;
            g_addr  <= addr[a_port*ADDR_W +: ADDR_W];
            g_wdata <= wdata[a_port*DATA_W +: DATA_W];
          end
        end
        S_ACCESS: begin
          state <= S_DONE;
          if (g_wr) begin
            wr_done[g_port] <= 1'b1;
          end else begin
            rd_done[g_port] <= 1'b1;
            rdata <= g_in_rng ? mem[g_addr] : '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
